stepper_phase_driver: RTL and testbench



---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_phase_driver_hold_pwm.sv | 44 ++++
 rtl/stepper_phase_driver.sv | 188 ++++++++++++++++++
 tb/tb_stepper_phase_driver.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// stepper_pkg
// Shared types and widths for the stepper output stage.
//   drv_state_t : driver FSM states (OFF, DEAD, DRIVE, HOLD)
//   COIL_W      : coil pattern width
//   STEP_CNT_W  : committed-step counter width
package stepper_pkg;

    localparam int COIL_W     = 4;
    localparam int STEP_CNT_W = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2,
        HOLD  = 2'd3
    } drv_state_t;

    // Coils allowed on while moving between two patterns (break-before-make).
    function automatic logic [COIL_W-1:0] coil_overlap(input logic [COIL_W-1:0] a,
                                                       input logic [COIL_W-1:0] b);
        return a & b;
    endfunction

endpackage

// File: rtl/stepper_phase_driver_hold_pwm.sv
// hold_pwm
// Holding-current PWM generator, only built with STEPPER_HOLD_PWM_EN.
// Ports:
//   clk   in  : clock
//   reset in  : synchronous active-high reset
//   run   in  : count while high; low parks the counter at 0
//   on    out : duty compare for the count loaded at the next edge, so the
//               parent's registered coil output lines up with the counter
`ifdef STEPPER_HOLD_PWM_EN
module hold_pwm #(
    parameter int PWM_PERIOD = 16,
    parameter int HOLD_DUTY  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic on
);

    localparam int CW = $clog2(PWM_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);

    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = '0;
        if (run) begin
            pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // 32-bit compare: HOLD_DUTY may equal PWM_PERIOD, which does not fit CW bits.
    assign on = (32'(pwm_cnt_d) < 32'(HOLD_DUTY));

endmodule
`endif

// File: rtl/stepper_phase_driver.sv
// stepper_phase_driver
// Coil output stage: applies break-before-make dead time on every pattern
// change, counts committed steps, and (optionally) drops to PWM holding
// current after an idle period.
// Optional feature macro: STEPPER_HOLD_PWM_EN (builds HOLD, idle counter and
// hold_pwm; otherwise DRIVE never times out and holding is tied 0).
// Ports:
//   clk             in      : clock
//   reset           in      : synchronous active-high reset
//   enable          in      : low forces coils off
//   stepper_signals in  [4] : requested coil pattern
//   coil_out        out [4] : registered coil drive
//   busy            out     : in DEAD
//   holding         out     : in HOLD
//   step_count      out [16]: committed phase changes, wrapping
module stepper_phase_driver
    import stepper_pkg::*;
#(
    parameter int DEAD_CYCLES  = 4,
    parameter int HOLD_TIMEOUT = 1000,
    parameter int PWM_PERIOD   = 16,
    parameter int HOLD_DUTY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [COIL_W-1:0]     stepper_signals,
    output logic [COIL_W-1:0]     coil_out,
    output logic                  busy,
    output logic                  holding,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

    drv_state_t              state_q, state_d;
    logic [COIL_W-1:0]       phase_q, phase_d;
    logic [COIL_W-1:0]       target_q, target_d;
    logic [COIL_W-1:0]       coil_q, coil_d;
    logic [DW-1:0]           dead_cnt_q, dead_cnt_d;
    logic [STEP_CNT_W-1:0]   step_count_q, step_count_d;
    logic                    pwm_on;

`ifdef STEPPER_HOLD_PWM_EN
    localparam int IW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(HOLD_TIMEOUT - 1);

    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          pwm_run;

    // Counter only advances while HOLD persists, so it reads 0 on the
    // first HOLD cycle and is parked again as soon as HOLD is left.
    assign pwm_run = (state_q == HOLD) && (state_d == HOLD);

    hold_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .HOLD_DUTY  (HOLD_DUTY)
    ) u_hold_pwm (
        .clk   (clk),
        .reset (reset),
        .run   (pwm_run),
        .on    (pwm_on)
    );
`else
    localparam int unused_cfg = HOLD_TIMEOUT + PWM_PERIOD + HOLD_DUTY;
    assign pwm_on = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        target_d     = target_q;
        coil_d       = coil_q;
        dead_cnt_d   = dead_cnt_q;
        step_count_d = step_count_q;
`ifdef STEPPER_HOLD_PWM_EN
        idle_cnt_d   = idle_cnt_q;
`endif
        if (!enable) begin
            // Pending target is dropped; step_count is retained.
            state_d    = OFF;
            phase_d    = '0;
            target_d   = '0;
            coil_d     = '0;
            dead_cnt_d = '0;
`ifdef STEPPER_HOLD_PWM_EN
            idle_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                OFF: begin
                    state_d    = DEAD;
                    phase_d    = '0;
                    target_d   = stepper_signals;
                    dead_cnt_d = DEAD_LAST;
                    coil_d     = '0;
                end
                DEAD: begin
                    if (stepper_signals != target_q) begin
                        // Retarget restarts the full dead interval.
                        target_d   = stepper_signals;
                        dead_cnt_d = DEAD_LAST;
                        coil_d     = coil_overlap(phase_q, stepper_signals);
                    end else if (dead_cnt_q == '0) begin
                        state_d      = DRIVE;
                        phase_d      = target_q;
                        coil_d       = target_q;
                        step_count_d = step_count_q + 1'b1;
`ifdef STEPPER_HOLD_PWM_EN
                        idle_cnt_d   = '0;
`endif
                    end else begin
                        dead_cnt_d = dead_cnt_q - 1'b1;
                        coil_d     = coil_overlap(phase_q, target_q);
                    end
                end
                DRIVE: begin
                    if (stepper_signals != phase_q) begin
                        state_d    = DEAD;
                        target_d   = stepper_signals;
                        dead_cnt_d = DEAD_LAST;
                        coil_d     = coil_overlap(phase_q, stepper_signals);
                    end else begin
                        coil_d = phase_q;
`ifdef STEPPER_HOLD_PWM_EN
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d = HOLD;
                            coil_d  = pwm_on ? phase_q : '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    // Pattern change overrides PWM phase immediately.
                    if (stepper_signals != phase_q) begin
                        state_d    = DEAD;
                        target_d   = stepper_signals;
                        dead_cnt_d = DEAD_LAST;
                        coil_d     = coil_overlap(phase_q, stepper_signals);
                    end else begin
                        coil_d = pwm_on ? phase_q : '0;
                    end
                end
                default: begin
                    state_d = OFF;
                    coil_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OFF;
            phase_q      <= '0;
            target_q     <= '0;
            coil_q       <= '0;
            dead_cnt_q   <= '0;
            step_count_q <= '0;
`ifdef STEPPER_HOLD_PWM_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            target_q     <= target_d;
            coil_q       <= coil_d;
            dead_cnt_q   <= dead_cnt_d;
            step_count_q <= step_count_d;
`ifdef STEPPER_HOLD_PWM_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign coil_out   = coil_q;
    assign busy       = (state_q == DEAD);
    assign step_count = step_count_q;
`ifdef STEPPER_HOLD_PWM_EN
    assign holding    = (state_q == HOLD);
`else
    assign holding    = 1'b0;
`endif

endmodule

// File: tb/tb_stepper_phase_driver.sv
module tb_stepper_phase_driver;

    localparam int DEAD_CYCLES  = 4;
    localparam int HOLD_TIMEOUT = 1000;
    localparam int PWM_PERIOD   = 16;
    localparam int HOLD_DUTY    = 4;
`ifdef STEPPER_HOLD_PWM_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  stepper_signals = 4'b0000;
    logic [3:0]  coil_out;
    logic        busy;
    logic        holding;
    logic [15:0] step_count;

    stepper_phase_driver #(
        .DEAD_CYCLES  (DEAD_CYCLES),
        .HOLD_TIMEOUT (HOLD_TIMEOUT),
        .PWM_PERIOD   (PWM_PERIOD),
        .HOLD_DUTY    (HOLD_DUTY)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .stepper_signals (stepper_signals),
        .coil_out        (coil_out),
        .busy            (busy),
        .holding         (holding),
        .step_count      (step_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: timestamps of pattern events, not counters.
    int          cyc = 0;
    bit          m_act, m_pend, m_hold;
    logic [3:0]  m_phase, m_tgt;
    logic [15:0] m_steps;
    int          t_set, t_commit, t_hold;

    function automatic logic [21:0] model_vec();
        logic [3:0] c;
        if (!m_act)      c = 4'b0000;
        else if (m_pend) c = m_phase & m_tgt;
        else if (m_hold) c = (((cyc - t_hold) % PWM_PERIOD) < HOLD_DUTY) ? m_phase : 4'b0000;
        else             c = m_phase;
        return {c, m_act && m_pend, m_hold, m_steps};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_act = 0; m_pend = 0; m_hold = 0;
            m_phase = '0; m_tgt = '0; m_steps = '0;
        end else if (!enable) begin
            m_act = 0; m_pend = 0; m_hold = 0; m_phase = '0;
        end else if (!m_act) begin
            m_act = 1; m_pend = 1; m_phase = '0; m_tgt = stepper_signals; t_set = cyc;
        end else if (m_pend) begin
            if (stepper_signals != m_tgt) begin
                m_tgt = stepper_signals; t_set = cyc;
            end else if (cyc - t_set >= DEAD_CYCLES) begin
                m_phase = m_tgt; m_pend = 0; m_steps++; t_commit = cyc;
            end
        end else if (stepper_signals != m_phase) begin
            m_pend = 1; m_hold = 0; m_tgt = stepper_signals; t_set = cyc;
        end else if (HOLD_EN && !m_hold && (cyc - t_commit >= HOLD_TIMEOUT)) begin
            m_hold = 1; t_hold = cyc;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; stepper_signals = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== 22'h0)
                $display("FAIL reset cyc=%0d got coil=%b busy=%b hold=%b steps=%0d want all 0",
                         cyc, coil_out, busy, holding, step_count);
            else n_pass++;
        end
    endtask

    task automatic test_startup();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL startup_model cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
            n_checks++;
            if (i < 4 && {coil_out, busy} !== {4'b0000, 1'b1})
                $display("FAIL startup_dead i=%0d got coil=%b busy=%b want 0000/1", i, coil_out, busy);
            else if (i >= 4 && {coil_out, step_count} !== {4'b0011, 16'd1})
                $display("FAIL startup_drive i=%0d got coil=%b steps=%0d want 0011/1", i, coil_out, step_count);
            else n_pass++;
        end
    endtask

    task automatic test_phase_change();
        stepper_signals = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL change_model cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
            n_checks++;
            if (i < 4 && {coil_out, busy} !== {4'b0010, 1'b1})
                $display("FAIL change_dead i=%0d got coil=%b busy=%b want 0010/1", i, coil_out, busy);
            else if (i >= 4 && {coil_out, busy, step_count} !== {4'b0110, 1'b0, 16'd2})
                $display("FAIL change_drive i=%0d got coil=%b busy=%b steps=%0d want 0110/0/2",
                         i, coil_out, busy, step_count);
            else n_pass++;
        end
    endtask

    task automatic test_retarget();
        logic [15:0] s0;
        stepper_signals = 4'b0011;
        repeat (6) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL retarget_prep cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
        s0 = step_count;
        stepper_signals = 4'b0110;
        tick();
        n_checks++;
        if (coil_out !== 4'b0010)
            $display("FAIL retarget_first got coil=%b want 0010", coil_out);
        else n_pass++;
        stepper_signals = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL retarget_model cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
            n_checks++;
            if (i < 4 && {coil_out, step_count} !== {4'b0000, s0})
                $display("FAIL retarget_dead i=%0d got coil=%b steps=%0d want 0000/%0d", i, coil_out, step_count, s0);
            else if (i == 4 && {coil_out, step_count} !== {4'b1100, 16'(s0 + 16'd1)})
                $display("FAIL retarget_commit got coil=%b steps=%0d want 1100/%0d", coil_out, step_count, s0 + 16'd1);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        int on_cnt;
        stepper_signals = 4'b0110;
        for (int i = 0; i < HOLD_TIMEOUT + DEAD_CYCLES + 4; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL hold_wait cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
        n_checks++;
        if (holding !== HOLD_EN)
            $display("FAIL hold_entered got holding=%b want %b", holding, HOLD_EN);
        else n_pass++;
        on_cnt = 0;
        for (int i = 0; i < 2 * PWM_PERIOD; i++) begin
            tick();
            if (coil_out == 4'b0110) on_cnt++;
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL hold_pwm cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
        n_checks++;
        if (on_cnt !== (HOLD_EN ? 2 * HOLD_DUTY : 2 * PWM_PERIOD))
            $display("FAIL hold_duty got on_cycles=%0d want %0d", on_cnt,
                     HOLD_EN ? 2 * HOLD_DUTY : 2 * PWM_PERIOD);
        else n_pass++;
        stepper_signals = 4'b0011;
        tick();
        n_checks++;
        if ({coil_out, busy, holding} !== {4'b0010, 1'b1, 1'b0})
            $display("FAIL hold_exit got coil=%b busy=%b hold=%b want 0010/1/0", coil_out, busy, holding);
        else n_pass++;
        repeat (5) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL hold_exit_model cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        logic [15:0] s0;
        s0 = step_count;
        stepper_signals = 4'b1001;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        n_checks++;
        if ({coil_out, busy, step_count} !== {4'b0000, 1'b0, s0})
            $display("FAIL en_drop got coil=%b busy=%b steps=%0d want 0000/0/%0d", coil_out, busy, step_count, s0);
        else n_pass++;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL reenable_model cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
            n_checks++;
            if (i < 4 && {coil_out, busy} !== {4'b0000, 1'b1})
                $display("FAIL reenable_dead i=%0d got coil=%b busy=%b want 0000/1", i, coil_out, busy);
            else if (i == 4 && {coil_out, step_count} !== {4'b1001, 16'(s0 + 16'd1)})
                $display("FAIL reenable_commit got coil=%b steps=%0d want 1001/%0d", coil_out, step_count, s0 + 16'd1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r == 0);
            if (r < 4) enable = ~enable;
            else if (r < 30) stepper_signals = 4'($urandom);
            else if (r < 34) stepper_signals = m_phase;
            if (!enable && r > 95) enable = 1'b1;
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL random cyc=%0d sig=%b en=%b got %h want %h", cyc, stepper_signals, enable,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
        reset = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_hold();
        stepper_signals = 4'b0101;
        for (int i = 0; i < HOLD_TIMEOUT + DEAD_CYCLES + 8; i++) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL rsthold_wait cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({coil_out, busy, holding, step_count} !== 22'h0)
            $display("FAIL rsthold got coil=%b busy=%b hold=%b steps=%0d want all 0",
                     coil_out, busy, holding, step_count);
        else n_pass++;
        reset = 1'b0;
        repeat (6) begin
            tick();
            n_checks++;
            if ({coil_out, busy, holding, step_count} !== model_vec())
                $display("FAIL rsthold_after cyc=%0d got %h want %h", cyc,
                         {coil_out, busy, holding, step_count}, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_startup();
        test_phase_change();
        test_retarget();
        test_hold();
        test_enable_drop();
        test_random();
        test_reset_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
